// File: rtl/gerador_tom.sv
// gerador_tom -- note-to-buzzer tone generator.
//
// Accepts a 3-bit note code plus a start strobe. It then drives a square wave
// on the buzzer for DURACAO_CICLOS clocks, followed by PAUSA_CICLOS clocks of
// silence. fim_tom pulses for one cycle when the note finishes normally.
//
// Optional feature: define GERADOR_TOM_OITAVA_EN to add the oitava_alta input.
// When that input is sampled as 1 at acceptance, the note is played one
// octave higher (half-period >> 1).
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   tocar       in   start request (ignored while busy)
//   parar       in   abort request
//   nota        in   [2:0] note code, 0 = rest, 1..7 = do..si
//   oitava_alta in   (GERADOR_TOM_OITAVA_EN only) raise by one octave
//   som         out  square wave to the buzzer
//   ocupado     out  high while TOCANDO or PAUSA
//   fim_tom     out  one-cycle completion pulse
//   nota_atual  out  [2:0] latched note code, 0 when idle
//   db_estado   out  [1:0] state encoding for debug
module gerador_tom #(
  parameter int DURACAO_CICLOS = 500000,
  parameter int PAUSA_CICLOS   = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tocar,
  input  logic       parar,
  input  logic [2:0] nota,
`ifdef GERADOR_TOM_OITAVA_EN
  input  logic       oitava_alta,
`endif
  output logic       som,
  output logic       ocupado,
  output logic       fim_tom,
  output logic [2:0] nota_atual,
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    TOCANDO  = 2'b01,
    PAUSA    = 2'b10,
    INVALIDO = 2'b11
  } estado_t;

  localparam int MAX_CICLOS = (DURACAO_CICLOS > PAUSA_CICLOS) ? DURACAO_CICLOS : PAUSA_CICLOS;
  localparam int CW         = $clog2(MAX_CICLOS + 1);

  // Terminal counts: the counter is cleared on state entry, so the edge that
  // closes a phase of N cycles sees the counter at N-1.
  localparam logic [CW-1:0] DUR_FIM   = CW'(DURACAO_CICLOS - 1);
  localparam logic [CW-1:0] PAUSA_FIM = CW'(PAUSA_CICLOS - 1);

  // Half-period in 1 MHz clocks for each note code; rest has no period.
  function automatic logic [10:0] meio_periodo(input logic [2:0] n);
    logic [10:0] h;
    case (n)
      3'd1:    h = 11'd1908;
      3'd2:    h = 11'd1700;
      3'd3:    h = 11'd1515;
      3'd4:    h = 11'd1432;
      3'd5:    h = 11'd1275;
      3'd6:    h = 11'd1136;
      3'd7:    h = 11'd1012;
      default: h = 11'd0;
    endcase
    return h;
  endfunction

  estado_t       estado_r, estado_s;
  logic [CW-1:0] dur_r, dur_s;
  logic [10:0]   per_r, per_s;
  logic          som_r, som_s;
  logic          ocupado_r, ocupado_s;
  logic          fim_r, fim_s;
  logic [2:0]    nota_r, nota_s;
  logic [10:0]   meio_s;
`ifdef GERADOR_TOM_OITAVA_EN
  logic          oitava_r, oitava_s;
`endif

  // Effective half-period of the latched note (octave shift applied if enabled).
  always_comb begin
`ifdef GERADOR_TOM_OITAVA_EN
    if (oitava_r) begin
      meio_s = meio_periodo(nota_r) >> 1;
    end else begin
      meio_s = meio_periodo(nota_r);
    end
`else
    meio_s = meio_periodo(nota_r);
`endif
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    estado_s  = estado_r;
    dur_s     = dur_r;
    per_s     = per_r;
    som_s     = som_r;
    ocupado_s = ocupado_r;
    fim_s     = 1'b0;
    nota_s    = nota_r;
`ifdef GERADOR_TOM_OITAVA_EN
    oitava_s  = oitava_r;
`endif
    case (estado_r)
      OCIOSO: begin
        dur_s = {CW{1'b0}};
        per_s = 11'd0;
        som_s = 1'b0;
        // parar has priority over tocar when both arrive together
        if (tocar && !parar) begin
          estado_s  = TOCANDO;
          ocupado_s = 1'b1;
          nota_s    = nota;
`ifdef GERADOR_TOM_OITAVA_EN
          oitava_s  = oitava_alta;
`endif
        end else begin
          ocupado_s = 1'b0;
          nota_s    = 3'd0;
        end
      end
      TOCANDO: begin
        if (parar) begin
          estado_s  = OCIOSO;
          dur_s     = {CW{1'b0}};
          per_s     = 11'd0;
          som_s     = 1'b0;
          ocupado_s = 1'b0;
          nota_s    = 3'd0;
        end else if (dur_r == DUR_FIM) begin
          estado_s = PAUSA;
          dur_s    = {CW{1'b0}};
          per_s    = 11'd0;
          som_s    = 1'b0;
        end else begin
          dur_s = dur_r + CW'(1);
          if (nota_r != 3'd0) begin
            // wrap at HALF-1 so the first toggle lands HALF edges after acceptance
            if (per_r == (meio_s - 11'd1)) begin
              per_s = 11'd0;
              som_s = ~som_r;
            end else begin
              per_s = per_r + 11'd1;
            end
          end else begin
            som_s = 1'b0;
          end
        end
      end
      PAUSA: begin
        som_s = 1'b0;
        per_s = 11'd0;
        if (parar) begin
          estado_s  = OCIOSO;
          dur_s     = {CW{1'b0}};
          ocupado_s = 1'b0;
          nota_s    = 3'd0;
        end else if (dur_r == PAUSA_FIM) begin
          estado_s  = OCIOSO;
          dur_s     = {CW{1'b0}};
          ocupado_s = 1'b0;
          nota_s    = 3'd0;
          fim_s     = 1'b1;
        end else begin
          dur_s = dur_r + CW'(1);
        end
      end
      default: begin
        // unreachable encoding: return to idle with everything cleared
        estado_s  = OCIOSO;
        dur_s     = {CW{1'b0}};
        per_s     = 11'd0;
        som_s     = 1'b0;
        ocupado_s = 1'b0;
        nota_s    = 3'd0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r  <= OCIOSO;
      dur_r     <= {CW{1'b0}};
      per_r     <= 11'd0;
      som_r     <= 1'b0;
      ocupado_r <= 1'b0;
      fim_r     <= 1'b0;
      nota_r    <= 3'd0;
`ifdef GERADOR_TOM_OITAVA_EN
      oitava_r  <= 1'b0;
`endif
    end else begin
      estado_r  <= estado_s;
      dur_r     <= dur_s;
      per_r     <= per_s;
      som_r     <= som_s;
      ocupado_r <= ocupado_s;
      fim_r     <= fim_s;
      nota_r    <= nota_s;
`ifdef GERADOR_TOM_OITAVA_EN
      oitava_r  <= oitava_s;
`endif
    end
  end

  assign som        = som_r;
  assign ocupado    = ocupado_r;
  assign fim_tom    = fim_r;
  assign nota_atual = nota_r;
  assign db_estado  = estado_r;

endmodule

// File: tb/tb_gerador_tom.sv
// Scoreboard bench for gerador_tom with short durations (5000/1000).
// Stimulus pushes expected output events (som transitions, fim_tom pulses)
// with their edge numbers; a monitor pops and compares each event it sees.
module tb_gerador_tom;

  localparam int DUR = 5000;
  localparam int PAU = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tocar = 1'b0;
  logic       parar = 1'b0;
  logic [2:0] nota  = 3'd0;
`ifdef GERADOR_TOM_OITAVA_EN
  logic       oitava_alta = 1'b0;
`endif
  logic       som, ocupado, fim_tom;
  logic [2:0] nota_atual;
  logic [1:0] db_estado;

  gerador_tom #(.DURACAO_CICLOS(DUR), .PAUSA_CICLOS(PAU)) dut (
    .clock(clock), .reset(reset), .tocar(tocar), .parar(parar), .nota(nota),
`ifdef GERADOR_TOM_OITAVA_EN
    .oitava_alta(oitava_alta),
`endif
    .som(som), .ocupado(ocupado), .fim_tom(fim_tom),
    .nota_atual(nota_atual), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // edge counter: after rising edge n, cyc == n
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = som transition, 1 = fim_tom pulse
    int val;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind; e.val = val; e.at = at;
    exp_q.push_back(e);
  endtask

  // compare one observed event against the scoreboard head
  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at %0d expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_val", val, e.val);
      check("event_cycle", cyc, e.at);
    end
  endtask

  // monitor: sample away from the active edge
  logic som_prev = 1'b0;
  always @(negedge clock) begin
    if (som !== som_prev) begin
      observe(0, int'(som));
      som_prev = som;
    end
    if (fim_tom === 1'b1) observe(1, 1);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic start_note(input logic [2:0] n, output int e0);
    @(negedge clock);
    nota  = n;
    tocar = 1'b1;
    e0    = cyc + 1;
    @(negedge clock);
    tocar = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    // reset held with tocar high
    tocar = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_som", int'(som), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_fim", int'(fim_tom), 0);
    check("rst_nota", int'(nota_atual), 0);
    check("rst_estado", int'(db_estado), 0);
    tocar = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_idle", int'(ocupado), 0);

    // basic note: la
    start_note(3'd6, e0);
    push(0, 1, e0 + 1136); push(0, 0, e0 + 2272);
    push(0, 1, e0 + 3408); push(0, 0, e0 + 4544);
    push(1, 1, e0 + DUR + PAU);
    check("basic_ocupado", int'(ocupado), 1);
    check("basic_nota", int'(nota_atual), 6);
    check("basic_estado", int'(db_estado), 1);
    wait_until(e0 + DUR);
    check("basic_pausa_som", int'(som), 0);
    check("basic_pausa_estado", int'(db_estado), 2);
    wait_until(e0 + DUR + PAU + 1);
    check("basic_end_ocupado", int'(ocupado), 0);
    check("basic_end_nota", int'(nota_atual), 0);

    // rest note; a tocar while busy is ignored
    start_note(3'd0, e0);
    push(1, 1, e0 + DUR + PAU);
    wait_until(e0 + 99);
    nota = 3'd1; tocar = 1'b1;
    @(negedge clock);
    tocar = 1'b0;
    check("ignore_nota", int'(nota_atual), 0);
    check("ignore_ocupado", int'(ocupado), 1);
    wait_until(e0 + DUR + PAU + 1);
    check("rest_end_ocupado", int'(ocupado), 0);

    // tocar and parar together while idle: stays idle
    @(negedge clock);
    tocar = 1'b1; parar = 1'b1; nota = 3'd3;
    @(negedge clock);
    tocar = 1'b0; parar = 1'b0;
    check("both_estado", int'(db_estado), 0);
    check("both_ocupado", int'(ocupado), 0);

    // abort mid-note
    start_note(3'd1, e0);
    push(0, 1, e0 + 1908);
    push(0, 0, e0 + 3001);
    wait_until(e0 + 3000);
    parar = 1'b1;
    @(negedge clock);
    parar = 1'b0;
    check("abort_estado", int'(db_estado), 0);
    check("abort_ocupado", int'(ocupado), 0);
    check("abort_som", int'(som), 0);
    check("abort_nota", int'(nota_atual), 0);
    wait_until(e0 + 3001 + 4000);

    // back-to-back with tocar held high
    @(negedge clock);
    nota = 3'd7; tocar = 1'b1;
    e0 = cyc + 1;
    e1 = e0 + DUR + PAU + 1;
    push(0, 1, e0 + 1012); push(0, 0, e0 + 2024);
    push(0, 1, e0 + 3036); push(0, 0, e0 + 4048);
    push(1, 1, e0 + DUR + PAU);
    push(0, 1, e1 + 1012); push(0, 0, e1 + 2024);
    push(0, 1, e1 + 3036); push(0, 0, e1 + 4048);
    push(1, 1, e1 + DUR + PAU);
    wait_until(e0 + DUR + PAU);
    check("b2b_gap_estado", int'(db_estado), 0);
    wait_until(e1);
    tocar = 1'b0;
    check("b2b_second_ocupado", int'(ocupado), 1);
    check("b2b_second_nota", int'(nota_atual), 7);
    wait_until(e1 + DUR + PAU + 1);

`ifdef GERADOR_TOM_OITAVA_EN
    // octave up: la becomes 568-cycle half-period
    oitava_alta = 1'b1;
    start_note(3'd6, e0);
    oitava_alta = 1'b0;
    for (int k = 1; k <= 8; k++) push(0, k % 2, e0 + 568 * k);
    push(1, 1, e0 + DUR + PAU);
    wait_until(e0 + DUR + PAU + 1);
    check("oct_end_ocupado", int'(ocupado), 0);
`endif

    // reset mid-note: aborts, no fim_tom afterwards
    start_note(3'd6, e0);
    wait_until(e0 + 500);
    reset = 1'b0;
    #1;
    check("midrst_ocupado", int'(ocupado), 0);
    check("midrst_nota", int'(nota_atual), 0);
    @(negedge clock);
    reset = 1'b1;
    wait_until(e0 + 7500);

    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
